// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared state type and BCD constants for magnetron_timer
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SET  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;
    localparam int BEEP_TICKS   = 3;

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= BCD_W'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD digit register with load, decrement-with-wrap and borrow out
module bcd_down_digit
    import microwave_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load_en,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec_en,
    input  logic [BCD_W-1:0] wrap_val,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (load_en) begin
            digit_d = load_val;
        end else if (dec_en) begin
            digit_d = (digit_q == '0) ? wrap_val : digit_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Borrow ripples to the next more significant digit in the same cycle.
    assign borrow_out = dec_en && (digit_q == '0);
    assign digit      = digit_q;

endmodule

// File: rtl/magnetron_timer.sv
// rtl/magnetron_timer.sv - BCD MM:SS countdown for the magnetron; beep output when MAGNETRON_TIMER_BEEP_EN is defined
module magnetron_timer
    import microwave_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter bit DONE_HOLD = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clearn,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_digit,
    input  logic             magnetron_on,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_units,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_units,
    output logic             zero,
    output logic             timer_done
`ifdef MAGNETRON_TIMER_BEEP_EN
    ,
    output logic             beep
`endif
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
`ifdef MAGNETRON_TIMER_BEEP_EN
    logic          beep_q, beep_d;
    logic [1:0]    beep_cnt_q, beep_cnt_d;
`endif

    logic key_ok;
    logic presc_term;
    logic run_tick;
    logic last_second;
    logic shift_zero;
    logic done_event;
    logic b_su, b_st, b_mu, b_mt;

    assign key_ok      = clearn && key_valid && is_bcd(key_digit) && (state_q != RUN);
    assign presc_term  = (presc_q == PRESC_MAX);
    assign run_tick    = clearn && (state_q == RUN) && presc_term;
    assign last_second = ({min_tens, min_units, sec_tens} == '0) && (sec_units == BCD_W'(1));
    assign shift_zero  = ({min_units, sec_tens, sec_units, key_digit} == '0);
    // A borrow out of the top digit cannot occur from a nonzero time; treat it as done anyway.
    assign done_event  = run_tick && (last_second || b_mt);

    bcd_down_digit u_sec_units (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (~clearn),
        .load_en    (key_ok),
        .load_val   (key_digit),
        .dec_en     (run_tick),
        .wrap_val   (BCD_W'(DIGIT_MAX)),
        .digit      (sec_units),
        .borrow_out (b_su)
    );

    bcd_down_digit u_sec_tens (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (~clearn),
        .load_en    (key_ok),
        .load_val   (sec_units),
        .dec_en     (b_su),
        .wrap_val   (BCD_W'(SEC_TENS_MAX)),
        .digit      (sec_tens),
        .borrow_out (b_st)
    );

    bcd_down_digit u_min_units (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (~clearn),
        .load_en    (key_ok),
        .load_val   (sec_tens),
        .dec_en     (b_st),
        .wrap_val   (BCD_W'(DIGIT_MAX)),
        .digit      (min_units),
        .borrow_out (b_mu)
    );

    bcd_down_digit u_min_tens (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (~clearn),
        .load_en    (key_ok),
        .load_val   (min_units),
        .dec_en     (b_mu),
        .wrap_val   (BCD_W'(DIGIT_MAX)),
        .digit      (min_tens),
        .borrow_out (b_mt)
    );

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        done_d  = DONE_HOLD ? done_q : 1'b0;
        if (!clearn) begin
            state_d = IDLE;
            presc_d = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, SET, DONE: begin
                    if (key_ok) begin
                        state_d = shift_zero ? IDLE : SET;
                        done_d  = 1'b0;
                        if (state_q == DONE) begin
                            presc_d = '0;
                        end
                    end else if ((state_q == SET) && magnetron_on && !zero) begin
                        state_d = RUN;
`ifdef MAGNETRON_TIMER_BEEP_EN
                    end else if (state_q == DONE) begin
                        presc_d = presc_term ? '0 : presc_q + 1'b1;
`endif
                    end
                end
                RUN: begin
                    // Pausing keeps the prescaler phase so a resume completes the partial second.
                    presc_d = presc_term ? '0 : presc_q + 1'b1;
                    if (done_event) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (!magnetron_on) begin
                        state_d = SET;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef MAGNETRON_TIMER_BEEP_EN
    always_comb begin
        beep_d     = beep_q;
        beep_cnt_d = beep_cnt_q;
        if (!clearn || key_ok) begin
            beep_d     = 1'b0;
            beep_cnt_d = '0;
        end else if (done_event) begin
            beep_d     = 1'b1;
            beep_cnt_d = '0;
        end else if ((state_q == DONE) && presc_term && beep_q) begin
            beep_cnt_d = beep_cnt_q + 1'b1;
            if (beep_cnt_q == 2'(BEEP_TICKS - 1)) begin
                beep_d = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            done_q     <= 1'b0;
`ifdef MAGNETRON_TIMER_BEEP_EN
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            done_q     <= done_d;
`ifdef MAGNETRON_TIMER_BEEP_EN
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
`endif
        end
    end

    assign zero       = ({min_tens, min_units, sec_tens, sec_units} == '0);
    assign timer_done = done_q;
`ifdef MAGNETRON_TIMER_BEEP_EN
    assign beep       = beep_q;
`endif

endmodule

// File: tb/tb_magnetron_timer.sv
// tb/tb_magnetron_timer.sv - randomized and directed self-checking bench for magnetron_timer
module tb_magnetron_timer;

    localparam int TD     = 4;
    localparam bit DH     = 1'b1;
    localparam int S_IDLE = 0;
    localparam int S_SET  = 1;
    localparam int S_RUN  = 2;
    localparam int S_DONE = 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clearn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       magnetron_on;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic       zero;
    logic       timer_done;
`ifdef MAGNETRON_TIMER_BEEP_EN
    logic       beep;
`endif

    int checks = 0;
    int errors = 0;

    int m_min, m_sec, m_presc, m_state, m_bcnt;
    bit m_done, m_beep;

    magnetron_timer #(.TICK_DIV(TD), .DONE_HOLD(DH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .clearn       (clearn),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .magnetron_on (magnetron_on),
        .min_tens     (min_tens),
        .min_units    (min_units),
        .sec_tens     (sec_tens),
        .sec_units    (sec_units),
        .zero         (zero),
        .timer_done   (timer_done)
`ifdef MAGNETRON_TIMER_BEEP_EN
        ,
        .beep         (beep)
`endif
    );

    always #5 clk = ~clk;

    wire [15:0] disp = {min_tens, min_units, sec_tens, sec_units};

    function automatic logic [15:0] exp_disp();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    function automatic logic exp_zero();
        return (m_min == 0) && (m_sec == 0);
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_presc = 0; m_state = S_IDLE;
        m_done = 1'b0; m_beep = 1'b0; m_bcnt = 0;
    endtask

    // Time is kept as minutes and seconds integers; seconds above 59 count down literally.
    task automatic model_step();
        bit tick;
        bit was_done;
        if (!clearn) begin
            model_reset();
        end else if (m_state == S_RUN) begin
            tick = (m_presc == TD - 1);
            m_presc = tick ? 0 : m_presc + 1;
            if (tick) begin
                if (m_sec > 0) m_sec--;
                else begin m_min--; m_sec = 59; end
            end
            if (tick && m_min == 0 && m_sec == 0) begin
                m_state = S_DONE; m_done = 1'b1; m_beep = 1'b1; m_bcnt = 0;
            end else if (!magnetron_on) begin
                m_state = S_SET;
            end
        end else begin
            was_done = (m_state == S_DONE);
            if (!DH) m_done = 1'b0;
            if (key_valid && key_digit <= 4'd9) begin
                m_min = (m_min % 10) * 10 + m_sec / 10;
                m_sec = (m_sec % 10) * 10 + int'(key_digit);
                m_state = (m_min == 0 && m_sec == 0) ? S_IDLE : S_SET;
                m_done = 1'b0; m_beep = 1'b0; m_bcnt = 0;
                if (was_done) m_presc = 0;
            end else if (m_state == S_SET && magnetron_on) begin
                m_state = S_RUN;
            end
`ifdef MAGNETRON_TIMER_BEEP_EN
            else if (was_done) begin
                tick = (m_presc == TD - 1);
                m_presc = tick ? 0 : m_presc + 1;
                if (tick && m_beep) begin
                    m_bcnt++;
                    if (m_bcnt == 3) m_beep = 1'b0;
                end
            end
`endif
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; clearn = 1'b1; key_valid = 1'b0; key_digit = 4'd0; magnetron_on = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        checks++;
        if (disp !== 16'h0000 || zero !== 1'b1 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL reset got disp %h zero %b done %b want 0000 1 0", disp, zero, timer_done);
        end
    endtask

    task automatic test_countdown();
        do_clear();
        press(4'd1); press(4'd3); press(4'd0);
        checks++;
        if (disp !== 16'h0130) begin
            errors++;
            $display("FAIL entry_0130 got %h want 0130", disp);
        end
        magnetron_on = 1'b1;
        for (int i = 0; i < 361; i++) begin
            step();
            checks++;
            if (disp !== exp_disp() || zero !== exp_zero() || timer_done !== m_done) begin
                errors++;
                $display("FAIL countdown cyc %0d got %h/%b want %h/%b", i, disp, timer_done, exp_disp(), m_done);
            end
            if (i == 4) begin
                checks++;
                if (disp !== 16'h0129) begin
                    errors++;
                    $display("FAIL first_tick got %h want 0129", disp);
                end
            end
        end
        checks++;
        if (timer_done !== 1'b1 || disp !== 16'h0000 || zero !== 1'b1) begin
            errors++;
            $display("FAIL countdown_done got %h done %b want 0000 done 1", disp, timer_done);
        end
        magnetron_on = 1'b0;
    endtask

    task automatic test_pause();
        do_clear();
        press(4'd5);
        magnetron_on = 1'b1;
        repeat (10) step();
        magnetron_on = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (disp !== exp_disp() || timer_done !== m_done) begin
                errors++;
                $display("FAIL pause cyc %0d got %h want %h", i, disp, exp_disp());
            end
        end
        checks++;
        if (disp !== 16'h0003) begin
            errors++;
            $display("FAIL pause_hold got %h want 0003", disp);
        end
        magnetron_on = 1'b1;
        repeat (2) step();
        checks++;
        if (disp !== 16'h0003) begin
            errors++;
            $display("FAIL resume_early got %h want 0003", disp);
        end
        step();
        checks++;
        if (disp !== 16'h0002 || disp !== exp_disp()) begin
            errors++;
            $display("FAIL resume_tick got %h want 0002", disp);
        end
        magnetron_on = 1'b0;
        step();
    endtask

    task automatic test_ignored_keys();
        do_clear();
        press(4'd2); press(4'd0);
        magnetron_on = 1'b1;
        repeat (2) step();
        press(4'd7);
        checks++;
        if (disp !== 16'h0020 || disp !== exp_disp()) begin
            errors++;
            $display("FAIL key_in_run got %h want 0020", disp);
        end
        magnetron_on = 1'b0;
        step();
        press(4'hC);
        checks++;
        if (disp !== 16'h0020 || zero !== 1'b0 || disp !== exp_disp()) begin
            errors++;
            $display("FAIL bad_digit got %h want 0020", disp);
        end
    endtask

    task automatic test_borrow();
        do_clear();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        checks++;
        if (disp !== 16'h1000) begin
            errors++;
            $display("FAIL entry_1000 got %h want 1000", disp);
        end
        magnetron_on = 1'b1;
        repeat (5) step();
        checks++;
        if (disp !== 16'h0959) begin
            errors++;
            $display("FAIL borrow got %h want 0959", disp);
        end
        magnetron_on = 1'b0;
        step();
        do_clear();
        press(4'd7); press(4'd5);
        magnetron_on = 1'b1;
        for (int i = 0; i < 301; i++) begin
            step();
            checks++;
            if (disp !== exp_disp() || timer_done !== m_done) begin
                errors++;
                $display("FAIL sec75 cyc %0d got %h/%b want %h/%b", i, disp, timer_done, exp_disp(), m_done);
            end
        end
        checks++;
        if (disp !== 16'h0000 || timer_done !== 1'b1) begin
            errors++;
            $display("FAIL sec75_done got %h done %b want 0000 done 1", disp, timer_done);
        end
    endtask

    task automatic test_done_state();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (disp !== 16'h0000 || timer_done !== 1'b1) begin
                errors++;
                $display("FAIL done_hold cyc %0d got %h done %b want 0000 done 1", i, disp, timer_done);
            end
        end
        magnetron_on = 1'b0;
        press(4'd4);
        checks++;
        if (disp !== 16'h0004 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL key_in_done got %h done %b want 0004 done 0", disp, timer_done);
        end
        magnetron_on = 1'b1;
        repeat (17) step();
        clearn = 1'b0; key_valid = 1'b1; key_digit = 4'd3;
        step();
        clearn = 1'b1; key_valid = 1'b0;
        checks++;
        if (disp !== 16'h0000 || timer_done !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_key got %h done %b want 0000 done 0", disp, timer_done);
        end
        repeat (6) step();
        checks++;
        if (disp !== 16'h0000 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL mag_in_idle got %h done %b want 0000 done 0", disp, timer_done);
        end
        magnetron_on = 1'b0;
        press(4'd3);
        checks++;
        if (disp !== 16'h0003) begin
            errors++;
            $display("FAIL idle_entry got %h want 0003", disp);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        press(4'd1); press(4'd3); press(4'd0);
        magnetron_on = 1'b1;
        repeat (10) step();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (disp !== 16'h0000 || timer_done !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got %h done %b want 0000 done 0", disp, timer_done);
        end
        model_reset();
        magnetron_on = 1'b0;
        #3 rstn = 1'b1;
        press(4'd2);
        checks++;
        if (disp !== 16'h0002) begin
            errors++;
            $display("FAIL after_reset got %h want 0002", disp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            clearn    = ($urandom_range(0, 99) != 0);
            key_valid = ($urandom_range(0, 4) == 0);
            key_digit = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) magnetron_on = ~magnetron_on;
            step();
            checks++;
            if (disp !== exp_disp() || zero !== exp_zero() || timer_done !== m_done) begin
                errors++;
                $display("FAIL random cyc %0d got %h/%b/%b want %h/%b/%b", i, disp, zero, timer_done, exp_disp(), exp_zero(), m_done);
            end
`ifdef MAGNETRON_TIMER_BEEP_EN
            checks++;
            if (beep !== m_beep) begin
                errors++;
                $display("FAIL random_beep cyc %0d got %b want %b", i, beep, m_beep);
            end
`endif
        end
        clearn = 1'b1; key_valid = 1'b0; magnetron_on = 1'b0;
    endtask

`ifdef MAGNETRON_TIMER_BEEP_EN
    task automatic test_beep();
        int cnt;
        do_clear();
        press(4'd1);
        magnetron_on = 1'b1;
        repeat (5) step();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (beep === 1'b1) cnt++;
            step();
        end
        checks++;
        if (cnt != 3 * TD) begin
            errors++;
            $display("FAIL beep_len got %0d want %0d", cnt, 3 * TD);
        end
        magnetron_on = 1'b0;
        press(4'd1);
        magnetron_on = 1'b1;
        repeat (7) step();
        do_clear();
        checks++;
        if (beep !== 1'b0 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL beep_cancel got %b want 0", beep);
        end
        magnetron_on = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_ignored_keys();
        test_borrow();
        test_done_state();
        test_async_reset();
`ifdef MAGNETRON_TIMER_BEEP_EN
        test_beep();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/magnetron_timer.md
Name: magnetron_timer

Overview:
- Countdown timer that produces `timer_done` for the magnetron control block.
- Receives keypad digits and holds a 4-digit BCD MM:SS value.
- Decrements once per second while the magnetron is on, then flags completion.
- Sits between the keypad encoder and the control/latch stage. It also drives the display digits.

Parameters:
- TICK_DIV, 100, clk cycles per one-second tick (minimum 2).
- DONE_HOLD, 1, timer_done stays level-high until cleared (1) or pulses for one cycle (0).

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- clearn  input  1  synchronous active-low clear of time and done flag.
- key_valid  input  1  one-cycle strobe, keypad digit present.
- key_digit  input  4  BCD digit from keypad.
- magnetron_on  input  1  magnetron latch output; enables counting.
- min_tens  output  4  BCD display digit.
- min_units  output  4  BCD display digit.
- sec_tens  output  4  BCD display digit.
- sec_units  output  4  BCD display digit.
- zero  output  1  all four digits are 0 (combinational from registers).
- timer_done  output  1  countdown reached 00:00 while running.
- beep  output  1  only present with the optional feature.

Behaviour:
- Reset (rstn=0, async): all digits 0, prescaler 0, state IDLE, timer_done 0, beep 0.
- States:
  - IDLE: time is zero, not done.
  - SET: nonzero time, not counting.
  - RUN: counting.
  - DONE: reached zero.
- clearn=0 has highest synchronous priority. It forces digits to 0, prescaler to 0, timer_done to 0 and state to IDLE, and it overrides key_valid and ticks in the same cycle.
- Key entry (IDLE, SET, DONE only):
  - key_valid with key_digit<=9 shifts digits left: min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=key_digit.
  - Next state is SET if the result is nonzero, else IDLE.
  - A key in DONE clears timer_done.
  - key_digit>9 is ignored.
  - key_valid in RUN is ignored.
- SET->RUN when magnetron_on=1 and time is nonzero. RUN->SET when magnetron_on falls; the prescaler value is held (pause), not reset.
- In RUN, the prescaler counts 0..TICK_DIV-1. At terminal count it wraps to 0 and issues a tick, so the first decrement comes TICK_DIV cycles after entering RUN.
- Tick decrements BCD MM:SS:
  - If sec_units>0: sec_units-1.
  - Else if sec_tens>0: sec_tens-1, sec_units=9.
  - Else if minutes are nonzero: borrow, sec_tens=5, sec_units=9, and minutes decrement the same way (min_units wraps 0->9 with min_tens-1).
  - Entered seconds above 59 (e.g. 0:75) are legal and count down literally (75 ticks).
- When a tick yields 00:00, the next state is DONE and timer_done=1 from the following cycle.
  - DONE_HOLD=1: timer_done stays high until clearn or a key.
  - DONE_HOLD=0: it is high for exactly one cycle.
- In DONE, magnetron_on is ignored and no further decrement occurs; 00:00 never underflows.
- magnetron_on=1 in IDLE: no effect, timer_done stays 0.
- Simultaneous magnetron_on fall and tick in the same cycle: the tick is applied, then the state becomes SET (or DONE if the result is zero).

Optional Feature:
- Macro: MAGNETRON_TIMER_BEEP_EN.
- Defined: port beep exists. beep=1 for exactly 3 ticks (3*TICK_DIV cycles) starting the cycle timer_done rises, using the prescaler free-running in DONE. It is cancelled immediately by clearn or a key.
- Not defined: beep port and its logic are absent; the prescaler only runs in RUN.

Decomposition:
- Package microwave_pkg:
  - state enum (IDLE, SET, RUN, DONE), 2-bit.
  - BCD_W=4, SEC_TENS_MAX=5, DIGIT_MAX=9.
  - BEEP_TICKS=3.
- Sub-module bcd_down_digit: one BCD digit with load value, decrement enable, wrap value input, and borrow_out when the digit is 0 on decrement. Instantiate four times with the borrow chained.

Test Plan:
- Reset mid-RUN at 01:30: assert rstn=0 asynchronously -> all digits 0, timer_done 0 within the same cycle, state IDLE.
- Keys 1,3,0 then magnetron_on=1, TICK_DIV=4 -> display shows 01:30 → after 4 cycles 01:29 → ... → 00:00 after 90 ticks; timer_done=1 on the next cycle.
- 00:05 running, drop magnetron_on after 2 ticks plus 1 cycle, wait 20 cycles, reassert -> value holds at 00:03. The next decrement comes TICK_DIV-1 cycles after the reassert (prescaler not reset).
- In RUN, send key_valid with digit 7 -> ignored, digits unchanged. In SET, send key_digit=4'hC -> ignored.
- Borrow chain: load 10:00 and tick once -> 09:59. Load 0:75 and tick 75 times -> 00:00 then timer_done.
- DONE state: clearn=0 together with key_valid -> digits 0, timer_done 0, IDLE, key discarded. With MAGNETRON_TIMER_BEEP_EN, beep=1 for exactly 3*TICK_DIV cycles after done, and is cut short by clearn.
